// File: rtl/cv32e40p_obi_shadow_arbiter_if.sv
// Bundle of the core data, shadow-store and merged OBI ports of the shadow arbiter.
// The arbiter takes the slave view; the environment driving it takes the master view.
interface cv32e40p_obi_shadow_arbiter_if #(
  parameter int MAX_OUTSTANDING = 2
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             data_req_i;
  logic             data_gnt_o;
  logic             data_rvalid_o;
  logic             data_we_i;
  logic [3:0]       data_be_i;
  logic [31:0]      data_addr_i;
  logic [31:0]      data_wdata_i;
  logic [31:0]      data_rdata_o;

  logic             shadow_req_i;
  logic             shadow_gnt_o;
  logic             shadow_rvalid_o;
  logic             shadow_we_i;
  logic [3:0]       shadow_be_i;
  logic [31:0]      shadow_addr_i;
  logic [31:0]      shadow_wdata_i;
  logic [31:0]      shadow_rdata_o;

  logic             obi_req_o;
  logic             obi_gnt_i;
  logic             obi_rvalid_i;
  logic             obi_we_o;
  logic [3:0]       obi_be_o;
  logic [31:0]      obi_addr_o;
  logic [31:0]      obi_wdata_o;
  logic [31:0]      obi_rdata_i;

  logic [CNT_W-1:0] outstanding_o;
  logic             resp_err_o;

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    input  shadow_req_i, shadow_we_i, shadow_be_i, shadow_addr_i,
    input  shadow_wdata_i,
    output shadow_gnt_o, shadow_rvalid_o, shadow_rdata_o,
    output obi_req_o, obi_we_o, obi_be_o, obi_addr_o, obi_wdata_o,
    input  obi_gnt_i, obi_rvalid_i, obi_rdata_i,
    output outstanding_o, resp_err_o
  );

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    output shadow_req_i, shadow_we_i, shadow_be_i, shadow_addr_i,
    output shadow_wdata_i,
    input  shadow_gnt_o, shadow_rvalid_o, shadow_rdata_o,
    input  obi_req_o, obi_we_o, obi_be_o, obi_addr_o, obi_wdata_o,
    output obi_gnt_i, obi_rvalid_i, obi_rdata_i,
    input  outstanding_o, resp_err_o
  );
endinterface

// File: rtl/cv32e40p_obi_shadow_arbiter.sv
// Merges core data and shadow-store OBI ports onto one in-order OBI master.
// Optional anti-starvation for shadow: define CV32E40P_SHADOW_ANTISTARVE_EN.
module cv32e40p_obi_shadow_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  cv32e40p_obi_shadow_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       lock_q;
  logic                       lock_src_q;
  logic                       resp_err_q;

  logic sel_shadow;
  logic sel_req;
  logic any_req;
  logic full;
  logic fwd_req;
  logic push;
  logic pop;
  logic head;
  logic force_shadow;

`ifdef CV32E40P_SHADOW_ANTISTARVE_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  logic [STARVE_W-1:0] starve_q;

  assign force_shadow = !lock_q && bus.shadow_req_i &&
                        (starve_q == STARVE_MAX);

  // Counts data wins while shadow waits; saturates at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else if (!bus.shadow_req_i || bus.shadow_gnt_o) begin
      starve_q <= '0;
    end else if (bus.data_gnt_o && starve_q != STARVE_MAX) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign force_shadow = 1'b0;
`endif

  always_comb begin
    sel_shadow = 1'b0;
    if (lock_q) begin
      sel_shadow = lock_src_q;
    end else begin
      sel_shadow = force_shadow || (!bus.data_req_i && bus.shadow_req_i);
    end
  end

  assign sel_req = sel_shadow ? bus.shadow_req_i : bus.data_req_i;
  assign any_req = bus.data_req_i | bus.shadow_req_i;
  assign full    = (count_q == FULL_CNT);
  assign fwd_req = sel_req && !full && !rst_i;
  assign push    = fwd_req && bus.obi_gnt_i;
  assign pop     = bus.obi_rvalid_i && (count_q != '0) && !rst_i;
  assign head    = tag_q[rd_ptr_q];

  assign bus.obi_req_o = fwd_req;
  assign bus.obi_we_o  = any_req &&
    (sel_shadow ? bus.shadow_we_i : bus.data_we_i);
  assign bus.obi_be_o  = !any_req ? '0 :
    (sel_shadow ? bus.shadow_be_i : bus.data_be_i);
  assign bus.obi_addr_o = !any_req ? '0 :
    (sel_shadow ? bus.shadow_addr_i : bus.data_addr_i);
  assign bus.obi_wdata_o = !any_req ? '0 :
    (sel_shadow ? bus.shadow_wdata_i : bus.data_wdata_i);

  assign bus.data_gnt_o      = push && !sel_shadow;
  assign bus.shadow_gnt_o    = push && sel_shadow;
  assign bus.data_rvalid_o   = pop && !head;
  assign bus.shadow_rvalid_o = pop && head;
  assign bus.data_rdata_o    = bus.obi_rdata_i;
  assign bus.shadow_rdata_o  = bus.obi_rdata_i;
  assign bus.outstanding_o   = count_q;
  assign bus.resp_err_o      = resp_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      // Hold the selection while the address phase waits for a grant.
      lock_q <= fwd_req && !bus.obi_gnt_i;
      if (fwd_req && !bus.obi_gnt_i) begin
        lock_src_q <= sel_shadow;
      end
      if (push) begin
        tag_q[wr_ptr_q] <= sel_shadow;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (bus.obi_rvalid_i && count_q == '0) begin
        resp_err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cv32e40p_obi_shadow_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic
// compared against a queue-based model of the arbiter.
module tb_cv32e40p_obi_shadow_arbiter;
  localparam int MAXO  = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cv32e40p_obi_shadow_arbiter_if #(.MAX_OUTSTANDING(MAXO)) bus ();

  cv32e40p_obi_shadow_arbiter #(
    .MAX_OUTSTANDING(MAXO),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_req_i     = 0; bus.data_we_i   = 0; bus.data_be_i   = '0;
    bus.data_addr_i    = '0; bus.data_wdata_i = '0;
    bus.shadow_req_i   = 0; bus.shadow_we_i = 0; bus.shadow_be_i = '0;
    bus.shadow_addr_i  = '0; bus.shadow_wdata_i = '0;
    bus.obi_gnt_i      = 0; bus.obi_rvalid_i = 0; bus.obi_rdata_i = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus.data_req_i = 1;
    bus.obi_gnt_i  = 1;
    bus.obi_rvalid_i = 1;
    #2;
    checks++;
    if ({bus.obi_req_o, bus.data_gnt_o, bus.shadow_gnt_o,
         bus.data_rvalid_o, bus.shadow_rvalid_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=00000",
        {bus.obi_req_o, bus.data_gnt_o, bus.shadow_gnt_o,
         bus.data_rvalid_o, bus.shadow_rvalid_o});
    end
    checks++;
    if (bus.outstanding_o !== 0 || bus.resp_err_o !== 0) begin
      failures++;
      $display("FAIL reset_state outstanding=%0d err=%b want 0/0",
        bus.outstanding_o, bus.resp_err_o);
    end
    idle_inputs();
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_single_read();
    apply_reset();
    tick();
    bus.data_req_i = 1; bus.data_addr_i = 32'h1000; bus.obi_gnt_i = 1;
    #1;
    checks++;
    if (bus.data_gnt_o !== 1 || bus.shadow_gnt_o !== 0 ||
        bus.obi_req_o !== 1 || bus.obi_addr_o !== 32'h1000) begin
      failures++;
      $display("FAIL single_req gnt=%b sgnt=%b req=%b addr=%h want 1/0/1/1000",
        bus.data_gnt_o, bus.shadow_gnt_o, bus.obi_req_o, bus.obi_addr_o);
    end
    tick();
    idle_inputs();
    bus.obi_rvalid_i = 1; bus.obi_rdata_i = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus.outstanding_o !== 1 || bus.data_rvalid_o !== 1 ||
        bus.shadow_rvalid_o !== 0 || bus.data_rdata_o !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_resp out=%0d rv=%b srv=%b rdata=%h",
        bus.outstanding_o, bus.data_rvalid_o, bus.shadow_rvalid_o,
        bus.data_rdata_o);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.outstanding_o !== 0) begin
      failures++;
      $display("FAIL single_drain outstanding=%0d want 0", bus.outstanding_o);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    tick();
    bus.shadow_req_i = 1; bus.shadow_addr_i = 32'h2000;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        bus.data_req_i = 1; bus.data_addr_i = 32'h3000;
      end
      #1;
      checks++;
      if (bus.obi_addr_o !== 32'h2000 || bus.obi_req_o !== 1 ||
          bus.data_gnt_o !== 0) begin
        failures++;
        $display("FAIL lock_hold c=%0d addr=%h req=%b dgnt=%b want 2000/1/0",
          c, bus.obi_addr_o, bus.obi_req_o, bus.data_gnt_o);
      end
      tick();
    end
    bus.obi_gnt_i = 1;
    #1;
    checks++;
    if (bus.shadow_gnt_o !== 1 || bus.data_gnt_o !== 0 ||
        bus.obi_addr_o !== 32'h2000) begin
      failures++;
      $display("FAIL lock_grant sgnt=%b dgnt=%b addr=%h want 1/0/2000",
        bus.shadow_gnt_o, bus.data_gnt_o, bus.obi_addr_o);
    end
    tick();
    bus.shadow_req_i = 0;
    #1;
    checks++;
    if (bus.data_gnt_o !== 1 || bus.obi_addr_o !== 32'h3000) begin
      failures++;
      $display("FAIL lock_next dgnt=%b addr=%h want 1/3000",
        bus.data_gnt_o, bus.obi_addr_o);
    end
    tick();
    idle_inputs();
    bus.obi_rvalid_i = 1;
    #1;
    checks++;
    if (bus.shadow_rvalid_o !== 1 || bus.data_rvalid_o !== 0) begin
      failures++;
      $display("FAIL lock_resp1 srv=%b drv=%b want 1/0",
        bus.shadow_rvalid_o, bus.data_rvalid_o);
    end
    tick();
    #1;
    checks++;
    if (bus.shadow_rvalid_o !== 0 || bus.data_rvalid_o !== 1) begin
      failures++;
      $display("FAIL lock_resp2 srv=%b drv=%b want 0/1",
        bus.shadow_rvalid_o, bus.data_rvalid_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_full();
    apply_reset();
    tick();
    bus.data_req_i = 1; bus.obi_gnt_i = 1;
    tick();
    tick();
    #1;
    checks++;
    if (bus.outstanding_o !== 2 || bus.obi_req_o !== 0 ||
        bus.data_gnt_o !== 0) begin
      failures++;
      $display("FAIL full_block out=%0d req=%b gnt=%b want 2/0/0",
        bus.outstanding_o, bus.obi_req_o, bus.data_gnt_o);
    end
    bus.obi_rvalid_i = 1;
    #1;
    checks++;
    if (bus.obi_req_o !== 0 || bus.data_rvalid_o !== 1) begin
      failures++;
      $display("FAIL full_nobypass req=%b rv=%b want 0/1",
        bus.obi_req_o, bus.data_rvalid_o);
    end
    tick();
    bus.obi_rvalid_i = 0;
    #1;
    checks++;
    if (bus.obi_req_o !== 1 || bus.data_gnt_o !== 1 ||
        bus.outstanding_o !== 1) begin
      failures++;
      $display("FAIL full_resume req=%b gnt=%b out=%0d want 1/1/1",
        bus.obi_req_o, bus.data_gnt_o, bus.outstanding_o);
    end
    tick();
    idle_inputs();
    bus.obi_rvalid_i = 1;
    tick();
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.outstanding_o !== 0 || bus.resp_err_o !== 0) begin
      failures++;
      $display("FAIL full_drain out=%0d err=%b want 0/0",
        bus.outstanding_o, bus.resp_err_o);
    end
  endtask

  task automatic test_ordering();
    apply_reset();
    tick();
    bus.data_req_i = 1; bus.obi_gnt_i = 1;
    tick();
    bus.data_req_i = 0; bus.shadow_req_i = 1; bus.obi_rvalid_i = 1;
    bus.obi_rdata_i = 32'h1234_5678;
    #1;
    checks++;
    if (bus.shadow_gnt_o !== 1 || bus.data_rvalid_o !== 1 ||
        bus.shadow_rvalid_o !== 0) begin
      failures++;
      $display("FAIL order_pushpop sgnt=%b drv=%b srv=%b want 1/1/0",
        bus.shadow_gnt_o, bus.data_rvalid_o, bus.shadow_rvalid_o);
    end
    tick();
    bus.shadow_req_i = 0; bus.obi_gnt_i = 0; bus.obi_rdata_i = 32'hCAFE0001;
    #1;
    checks++;
    if (bus.outstanding_o !== 1 || bus.shadow_rvalid_o !== 1 ||
        bus.data_rvalid_o !== 0 || bus.shadow_rdata_o !== 32'hCAFE0001) begin
      failures++;
      $display("FAIL order_second out=%0d srv=%b drv=%b rdata=%h",
        bus.outstanding_o, bus.shadow_rvalid_o, bus.data_rvalid_o,
        bus.shadow_rdata_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_spurious();
    apply_reset();
    tick();
    bus.obi_rvalid_i = 1;
    #1;
    checks++;
    if (bus.data_rvalid_o !== 0 || bus.shadow_rvalid_o !== 0) begin
      failures++;
      $display("FAIL spur_rvalid drv=%b srv=%b want 0/0",
        bus.data_rvalid_o, bus.shadow_rvalid_o);
    end
    tick();
    bus.obi_rvalid_i = 0;
    tick();
    checks++;
    if (bus.resp_err_o !== 1 || bus.outstanding_o !== 0) begin
      failures++;
      $display("FAIL spur_sticky err=%b out=%0d want 1/0",
        bus.resp_err_o, bus.outstanding_o);
    end
    apply_reset();
    checks++;
    if (bus.resp_err_o !== 0) begin
      failures++;
      $display("FAIL spur_clear err=%b want 0", bus.resp_err_o);
    end
    tick();
    bus.data_req_i = 1; bus.obi_gnt_i = 1;
    tick();
    idle_inputs();
    rst = 1;
    #2;
    rst = 0;
    #1;
    checks++;
    if (bus.outstanding_o !== 0 || bus.resp_err_o !== 0) begin
      failures++;
      $display("FAIL midreset out=%0d err=%b want 0/0",
        bus.outstanding_o, bus.resp_err_o);
    end
    tick();
    bus.obi_rvalid_i = 1;
    tick();
    bus.obi_rvalid_i = 0;
    #1;
    checks++;
    if (bus.resp_err_o !== 1) begin
      failures++;
      $display("FAIL late_resp err=%b want 1", bus.resp_err_o);
    end
  endtask

  task automatic test_starve();
    string got;
    string want;
    apply_reset();
    tick();
    got = "";
    want = "";
    bus.data_req_i = 1; bus.shadow_req_i = 1; bus.obi_gnt_i = 1;
    for (int i = 0; i < 10; i++) begin
      bus.obi_rvalid_i = (i > 0);
      #1;
      if (bus.data_gnt_o === 1'b1 && bus.shadow_gnt_o !== 1'b1) got = {got, "D"};
      else if (bus.shadow_gnt_o === 1'b1 && bus.data_gnt_o !== 1'b1) got = {got, "S"};
      else got = {got, "x"};
`ifdef CV32E40P_SHADOW_ANTISTARVE_EN
      want = {want, ((i % (LIMIT + 1)) == LIMIT) ? "S" : "D"};
`else
      want = {want, "D"};
`endif
      tick();
    end
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL starve_pattern got=%s want=%s", got, want);
    end
    idle_inputs();
    bus.obi_rvalid_i = 1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.outstanding_o !== 0 || bus.resp_err_o !== 0) begin
      failures++;
      $display("FAIL starve_drain out=%0d err=%b want 0/0",
        bus.outstanding_o, bus.resp_err_o);
    end
  endtask

  task automatic test_random();
    int q[$];
    int held;
    int win;
    int starve;
    bit full;
    bit exp_req;
    bit force_s;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_we;
    int errs;
    apply_reset();
    held = -1;
    starve = 0;
    errs = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (held != 0) begin
        bus.data_req_i   = ($urandom_range(0, 99) < 55);
        bus.data_we_i    = $urandom_range(0, 1);
        bus.data_be_i    = 4'($urandom);
        bus.data_addr_i  = $urandom;
        bus.data_wdata_i = $urandom;
      end
      if (held != 1) begin
        bus.shadow_req_i   = ($urandom_range(0, 99) < 55);
        bus.shadow_we_i    = $urandom_range(0, 1);
        bus.shadow_be_i    = 4'($urandom);
        bus.shadow_addr_i  = $urandom;
        bus.shadow_wdata_i = $urandom;
      end
      bus.obi_gnt_i    = ($urandom_range(0, 99) < 60);
      bus.obi_rvalid_i = (q.size() > 0) && ($urandom_range(0, 99) < 50);
      bus.obi_rdata_i  = $urandom;
`ifdef CV32E40P_SHADOW_ANTISTARVE_EN
      force_s = (held < 0) && bus.shadow_req_i && (starve == LIMIT);
`else
      force_s = 0;
`endif
      if (held >= 0) win = held;
      else if (force_s) win = 1;
      else if (bus.data_req_i) win = 0;
      else if (bus.shadow_req_i) win = 1;
      else win = -1;
      full = (q.size() == MAXO);
      exp_req = (win >= 0) && !full;
      exp_addr  = (win == 1) ? bus.shadow_addr_i  : bus.data_addr_i;
      exp_wdata = (win == 1) ? bus.shadow_wdata_i : bus.data_wdata_i;
      exp_be    = (win == 1) ? bus.shadow_be_i    : bus.data_be_i;
      exp_we    = (win == 1) ? bus.shadow_we_i    : bus.data_we_i;
      #1;
      checks++;
      if (bus.obi_req_o !== exp_req ||
          bus.data_gnt_o !== (exp_req && bus.obi_gnt_i && win == 0) ||
          bus.shadow_gnt_o !== (exp_req && bus.obi_gnt_i && win == 1) ||
          bus.data_rvalid_o !== (bus.obi_rvalid_i && q.size() > 0 && q[0] == 0) ||
          bus.shadow_rvalid_o !== (bus.obi_rvalid_i && q.size() > 0 && q[0] == 1) ||
          bus.outstanding_o !== q.size() || bus.resp_err_o !== 0 ||
          (exp_req && (bus.obi_addr_o !== exp_addr ||
                       bus.obi_wdata_o !== exp_wdata ||
                       bus.obi_be_o !== exp_be || bus.obi_we_o !== exp_we))) begin
        failures++;
        errs++;
        if (errs < 10)
          $display("FAIL random cyc=%0d req=%b/%b gnt=%b%b rv=%b%b out=%0d/%0d addr=%h/%h",
            cyc, bus.obi_req_o, exp_req, bus.data_gnt_o, bus.shadow_gnt_o,
            bus.data_rvalid_o, bus.shadow_rvalid_o, bus.outstanding_o,
            q.size(), bus.obi_addr_o, exp_addr);
      end
      if (bus.obi_rvalid_i && q.size() > 0) void'(q.pop_front());
      if (!bus.shadow_req_i || (exp_req && bus.obi_gnt_i && win == 1)) starve = 0;
      else if (exp_req && bus.obi_gnt_i && win == 0 && starve < LIMIT) starve++;
      if (exp_req && bus.obi_gnt_i) begin
        q.push_back(win);
        held = -1;
      end else if (exp_req) begin
        held = win;
      end else begin
        held = -1;
      end
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_lock();
    test_full();
    test_ordering();
    test_spurious();
    test_starve();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cv32e40p_obi_shadow_arbiter.md
Name: cv32e40p_obi_shadow_arbiter

Overview:
- Sits directly downstream of the core wrapper.
- Merges the core data OBI port and the shadow-store OBI port into one OBI master port toward the data interconnect.
- Fixed priority with request locking; tracks outstanding transactions in order and routes each response back to the originating port.
- Used whenever SHADOW=1, so shadow register saves share the single data bus.

Parameters:
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions (1..8); sets source-tag FIFO depth
STARVE_LIMIT, 4, consecutive data grants with shadow pending before shadow is forced (optional feature only)
CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived, not overridden)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous and active-high
data_req_i/data_gnt_o/data_rvalid_o  in/out/out  1 each  core data OBI handshake
data_we_i  in  1; data_be_i  in  4; data_addr_i  in  32; data_wdata_i  in  32; data_rdata_o  out  32
shadow_req_i/shadow_gnt_o/shadow_rvalid_o  in/out/out  1 each  shadow-store OBI handshake
shadow_we_i  in  1; shadow_be_i  in  4; shadow_addr_i  in  32; shadow_wdata_i  in  32; shadow_rdata_o  out  32
obi_req_o  out  1; obi_gnt_i  in  1; obi_rvalid_i  in  1  merged OBI handshake
obi_we_o  out  1; obi_be_o  out  4; obi_addr_o  out  32; obi_wdata_o  out  32; obi_rdata_i  in  32
outstanding_o  out  CNT_W  current outstanding count
resp_err_o  out  1  sticky: rvalid received with no outstanding transaction

Behaviour:
- State: tag FIFO (MAX_OUTSTANDING x 1 bit, 0=data, 1=shadow), count_q, lock_q, lock_src_q, resp_err_q.
- Reset (rst_i=1, async): FIFO empty, count_q=0, lock_q=0, resp_err_o=0, outstanding_o=0. obi_req_o, data_gnt_o, shadow_gnt_o, data_rvalid_o, shadow_rvalid_o are 0 while rst_i=1.
- Source select, combinational:
  - If lock_q, select lock_src_q.
  - Else data if data_req_i, else shadow if shadow_req_i.
- Blocking: full = (count_q==MAX_OUTSTANDING). When full, obi_req_o=0 and both gnt=0. No same-cycle rvalid->req bypass.
- Forwarding:
  - obi_req_o = selected req & !full.
  - obi_we/be/addr/wdata mux from the selected source; zero when neither source is requesting.
  - Grant goes to the selected source only: sel_gnt = obi_gnt_i & obi_req_o. The other source's gnt=0.
- Zero-latency request path: req in -> req out the same cycle; gnt passes through combinationally.
- Lock: if obi_req_o=1 and obi_gnt_i=0, set lock_q=1 and lock_src_q=selected at next edge. Clear on the grant cycle. A higher-priority data_req_i arriving while shadow is locked waits; OBI address-phase stability is guaranteed.
- Grant accepted (obi_req_o & obi_gnt_i): push source tag, count +1.
- Response (obi_rvalid_i): pop head tag, count -1. The head tag raises the matching *_rvalid_o in the same cycle (combinational). obi_rdata_i is broadcast to both rdata outputs.
- Push and pop in the same cycle: count unchanged, FIFO pointers both advance, order preserved. Pointers wrap modulo MAX_OUTSTANDING.
- rvalid with count_q==0: no rvalid_o asserted, count stays 0, resp_err_o set to 1 until reset.
- Reset mid-transaction: all outstanding state discarded; late responses after reset set resp_err_o.
- Responses return in grant order; the downstream slave is required to be in-order.

Optional Feature:
CV32E40P_SHADOW_ANTISTARVE_EN
- Defined:
  - A starve counter increments on each data grant while shadow_req_i=1 and the shadow request is not granted.
  - It resets on any shadow grant or when shadow_req_i=0.
  - When the counter reaches STARVE_LIMIT and lock_q=0, shadow is selected over data for the next arbitration; the counter clears on that grant.
- Undefined: strict data priority; shadow may starve indefinitely. Counter logic is absent.

Test Plan:
- Single data read: data_req_i=1, addr=0x1000, obi_gnt_i=1 same cycle -> data_gnt_o=1, outstanding_o=1; next cycle obi_rvalid_i=1, rdata=0xDEADBEEF -> data_rvalid_o=1, data_rdata_o=0xDEADBEEF, shadow_rvalid_o=0, outstanding_o=0.
- Lock: shadow_req_i=1 (addr 0x2000), obi_gnt_i=0 for 3 cycles, data_req_i rises in cycle 2 -> obi_addr_o stays 0x2000 until the grant; data granted on the following cycle.
- Full: MAX_OUTSTANDING=2, two grants without rvalid -> third request sees obi_req_o=0, data_gnt_o=0. One rvalid -> request forwarded the next cycle.
- Ordering: grant data, then shadow; rvalid twice -> first rvalid goes to data_rvalid_o, second to shadow_rvalid_o. Simultaneous push/pop keeps outstanding_o=1.
- Spurious response: obi_rvalid_i=1 with outstanding_o=0 -> no rvalid_o, resp_err_o=1 stays high; rst_i pulse clears it.
- Anti-starve (macro defined, STARVE_LIMIT=4): data_req_i and shadow_req_i both held high, gnt always 1 -> grants go D,D,D,D,S,D,D,D,D,S. Without the macro, all grants go to data.
